uart_tx_framed: RTL
===================

# uart_tx_framed

Parametrised UART transmitter with a configurable frame format and an input FIFO. Data bits, parity mode, stop-bit count and buffer depth are set by parameters. A valid/ready write port lets a producer queue several characters back-to-back. The block sits between the result/telemetry logic and the board TxD pin, and drives continuous frames with no idle gap while data is buffered.

## Interface
- CLK_FREQ, 100_000_000 — system clock in Hz
- BAUD_RATE, 115200 — line rate; DIV = CLK_FREQ / BAUD_RATE (integer division), clocks per bit, must be ≥ 2
- DATA_BITS, 8 — payload bits per frame, legal 5..9
- PARITY, 0 — 0 none, 1 odd, 2 even
- STOP_BITS, 1 — 1 or 2
- FIFO_DEPTH, 16 — write buffer entries, power of two ≥ 2
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- tx_valid  in  1  producer has a character on tx_data
- tx_data  in  DATA_BITS  character to send, LSB transmitted first
- tx_ready  out  1  FIFO not full; a write happens on any edge with tx_valid && tx_ready
- TxD  out  1  serial line, registered, idles high
- idle  out  1  high when the FSM is in IDLE and the FIFO is empty
- fifo_count  out  $clog2(FIFO_DEPTH+1)  entries currently buffered, excluding the frame in flight

## Operation
- The FIFO is a circular buffer with wrapping read/write pointers. Write on tx_valid && tx_ready. Pop only when the FSM loads a frame.
- Frame, in transmission order: start (0), DATA_BITS data LSB-first, optional parity, STOP_BITS stop bits (1). NBITS = 1 + DATA_BITS + (PARITY != 0) + STOP_BITS.
- Parity bit: even = XOR of the data bits; odd = inverted XOR. The bit is computed from the popped word at load time.
- FSM states:
  - IDLE: TxD = 1. If the FIFO is non-empty, pop, load the shift register with the full frame, drive TxD = 0, clear the baud and bit counters, go to SEND.
  - SEND: the baud counter runs 0..DIV-1. At DIV-1 it wraps to 0 and the next frame bit is driven on TxD; the bit counter increments. At the end of the last stop bit (bit counter = NBITS-1, baud counter = DIV-1):
    - if the FIFO is non-empty, pop and load the next frame in that same cycle, and TxD goes to 0 directly;
    - otherwise TxD stays 1 and the FSM goes to IDLE.
- Shift register width: 12 bits (9 data + parity + 2 stop). Unused upper bits are filled with 1. The baud counter is sized $clog2(DIV).
- Simultaneous push and pop: both occur and fifo_count is unchanged. When full, tx_ready = 0, so there is no push that cycle even if a pop frees an entry; tx_ready rises one cycle later.
- Reset (reset_n = 0 on an edge), including mid-frame:
  - TxD = 1, FSM = IDLE, counters = 0, FIFO pointers = 0, fifo_count = 0, tx_ready = 1, idle = 1;
  - any frame in flight is truncated and buffered data is discarded.

## Timing
- Write-to-line latency when idle and empty: write accepted at edge N; TxD falls at edge N+1.
- Every bit, including the first start bit, lasts exactly DIV cycles. Frame period = NBITS × DIV cycles.
- Back-to-back frames: the next start bit begins on the edge immediately after the last stop bit's DIV cycles, with zero extra cycles.
- idle falls on the same edge that loads the first frame, or the edge of the write if the FIFO was empty. It rises on the edge TxD completes the final stop bit with the FIFO empty.
- fifo_count updates on the edge of the push/pop. tx_ready = (fifo_count != FIFO_DEPTH), combinational from registered count.

## Test plan
- Basic 8-N-1 with CLK_FREQ=1_000_000, BAUD_RATE=100_000 (DIV=10): write 0xA5 -> TxD falls 1 cycle later, then bits 0,1,0,1,0,0,1,0,1,1 for 10 cycles each. idle rises after exactly 100 cycles.
- Parity and format, DATA_BITS=7, PARITY=1 (odd), STOP_BITS=2: write 0x41 -> 0,1,0,0,0,0,0,1,(parity 1),1,1. Repeat with PARITY=2 (even) -> parity bit 0.
- Burst/full, FIFO_DEPTH=4: hold tx_valid with 0x01..0x06 -> first word popped immediately. tx_ready drops when fifo_count=4 (after 5 accepts). All 6 frames are emitted with no gap between stop and start bits, in order.
- Simultaneous push/pop: with fifo_count=2, write on the edge a frame loads -> fifo_count stays 2.
- Reset mid-frame: assert reset_n=0 during data bit 3 -> TxD=1, fifo_count=0, idle=1 after the edge. No further frames until new writes; the next frame is complete and correct.
- Degenerate DIV=2: 8-N-1 of 0xFF -> start bit 2 cycles, stop bit 2 cycles, frame 20 cycles.

Source files
------------

// File: rtl/uart_tx_framed.sv
// UART transmitter with a parametrised frame format (data bits, parity, stop bits)
// and a write FIFO, so queued characters go out as back-to-back frames with no idle gap.
module uart_tx_framed #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              tx_valid,
  input  logic [DATA_BITS-1:0]              tx_data,
  output logic                              tx_ready,
  output logic                              TxD,
  output logic                              idle,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);
  localparam int DIV    = CLK_FREQ / BAUD_RATE;
  localparam int BAUD_W = $clog2(DIV);
  localparam int NBITS  = 1 + DATA_BITS + ((PARITY != 0) ? 1 : 0) + STOP_BITS;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIV - 1);
  localparam logic [3:0]        BIT_LAST  = 4'(NBITS - 1);
  localparam logic [CNT_W-1:0]  FULL      = CNT_W'(FIFO_DEPTH);

  typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;

  state_t               state_q, state_d;
  logic                 txd_q, txd_d;
  logic [11:0]          shreg_q, shreg_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [3:0]           bitcnt_q, bitcnt_d;
  logic [PTR_W-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic                 push, pop, empty;
  logic [DATA_BITS-1:0] head;

  // Everything after the start bit, LSB first; unused upper bits stay 1 (stop/idle level).
  function automatic logic [11:0] build_frame(input logic [DATA_BITS-1:0] d);
    logic [11:0] f;
    f = '1;
    f[DATA_BITS-1:0] = d;
    if (PARITY == 1)
      f[DATA_BITS] = ~(^d);
    else if (PARITY == 2)
      f[DATA_BITS] = ^d;
    return f;
  endfunction

  assign push  = tx_valid && tx_ready;
  assign empty = (count_q == '0);
  assign head  = mem[rptr_q];

  always_comb begin
    state_d  = state_q;
    txd_d    = txd_q;
    shreg_d  = shreg_q;
    baud_d   = baud_q;
    bitcnt_d = bitcnt_q;
    pop      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (!empty) begin
          pop      = 1'b1;
          shreg_d  = build_frame(head);
          txd_d    = 1'b0;
          baud_d   = '0;
          bitcnt_d = '0;
          state_d  = S_SEND;
        end
      end
      S_SEND: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bitcnt_q == BIT_LAST) begin
            // End of the last stop bit: chain straight into the next start bit if data waits.
            if (!empty) begin
              pop      = 1'b1;
              shreg_d  = build_frame(head);
              txd_d    = 1'b0;
              bitcnt_d = '0;
            end else begin
              txd_d   = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            txd_d    = shreg_q[0];
            shreg_d  = {1'b1, shreg_q[11:1]};
            bitcnt_d = bitcnt_q + 4'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + PTR_W'(1);
    if (pop)  rptr_d = rptr_q + PTR_W'(1);
    if (push && !pop)
      count_d = count_q + CNT_W'(1);
    else if (pop && !push)
      count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      txd_q    <= 1'b1;
      baud_q   <= '0;
      bitcnt_q <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      txd_q    <= txd_d;
      baud_q   <= baud_d;
      bitcnt_q <= bitcnt_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
    end
  end

  // Datapath storage carries no reset; it is only read after a load or a push.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
    if (push) mem[wptr_q] <= tx_data;
  end

  assign TxD        = txd_q;
  assign tx_ready   = (count_q != FULL);
  assign idle       = (state_q == S_IDLE) && empty;
  assign fifo_count = count_q;

endmodule
